// File: rtl/wb_arbiter_pkg.sv
// Shared widths, zero constants and the LLU result FIFO entry type.
// Imported by the arbiter interface, the FIFO and the arbiter top.
package wb_arbiter_pkg;

    localparam int RADDR_WIDTH = 5;
    localparam int RDATA_WIDTH = 32;

    localparam logic [RADDR_WIDTH-1:0] ZERO_REG = '0;
    localparam logic [RDATA_WIDTH-1:0] ZERO     = '0;

    typedef struct packed {
        logic [RADDR_WIDTH-1:0] waddr;
        logic [RDATA_WIDTH-1:0] wdata;
    } wb_entry_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle for wb_arbiter: pipeline writeback, LLU results, hazard check, regfile port.
// slave = the arbiter, master = the surrounding pipeline/regfile side.
interface wb_arbiter_if;
    import wb_arbiter_pkg::*;

    logic [RADDR_WIDTH-1:0] pipe_waddr_i;
    logic                   pipe_we_i;
    logic [RDATA_WIDTH-1:0] pipe_wdata_i;
    logic                   llu_valid_i;
    logic                   llu_ready_o;
    logic [RADDR_WIDTH-1:0] llu_waddr_i;
    logic [RDATA_WIDTH-1:0] llu_wdata_i;
    logic [RADDR_WIDTH-1:0] chk_raddr_i;
    logic                   chk_hit_o;
    logic                   stall_req_o;
    logic [RADDR_WIDTH-1:0] reg_waddr_o;
    logic                   reg_we_o;
    logic [RDATA_WIDTH-1:0] reg_wdata_o;

    modport slave (
        input  pipe_waddr_i, pipe_we_i, pipe_wdata_i,
        input  llu_valid_i, llu_waddr_i, llu_wdata_i, chk_raddr_i,
        output llu_ready_o, chk_hit_o, stall_req_o,
        output reg_waddr_o, reg_we_o, reg_wdata_o
    );

    modport master (
        output pipe_waddr_i, pipe_we_i, pipe_wdata_i,
        output llu_valid_i, llu_waddr_i, llu_wdata_i, chk_raddr_i,
        input  llu_ready_o, chk_hit_o, stall_req_o,
        input  reg_waddr_o, reg_we_o, reg_wdata_o
    );

endinterface

// File: rtl/wb_fifo.sv
// Circular FIFO of LLU results; exposes count, head and per-entry valid/address for hazard checks.
// Latency: pushed entry is poppable the next cycle. Backpressure: caller must not push when full or pop when empty.
// Simultaneous push and pop keeps the count and advances both pointers.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_n_i,
    input  logic                              push,
    input  logic                              pop,
    input  wb_entry_t                         din,
    output logic [$clog2(DEPTH):0]            count,
    output wb_entry_t                         head,
    output logic [DEPTH-1:0]                  ent_vld,
    output logic [DEPTH-1:0][RADDR_WIDTH-1:0] ent_waddr
);

    localparam int PW = $clog2(DEPTH);

    wb_entry_t         mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW:0]       cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + (PW+1)'(1);
                2'b01:   cnt <= cnt - (PW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: validity comes entirely from the pointers and count.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_comb begin
        logic [PW-1:0] off;
        ent_vld   = '0;
        ent_waddr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off          = PW'(i) - rd_ptr;
            ent_vld[i]   = ({1'b0, off} < cnt);
            ent_waddr[i] = mem[i].waddr;
        end
    end

    assign count = cnt;
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/wb_arbiter.sv
// Shares the regfile write port between pipeline writeback and buffered LLU results; optional WB_ARB_STARVE_EN bubble request.
// Latency: 1 cycle to reg_* for pipeline writes and for granted LLU entries (2 cycles minimum push-to-write).
// Backpressure: llu_ready_o drops while the FIFO is full; the pipeline is never stalled or dropped.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    wb_arbiter_if.slave  bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]                     count;
    wb_entry_t                         head;
    wb_entry_t                         din;
    logic [DEPTH-1:0]                  ent_vld;
    logic [DEPTH-1:0][RADDR_WIDTH-1:0] ent_waddr;
    logic                              slot_free;
    logic                              empty;
    logic                              grant;
    logic                              push;
    logic                              hit;

    assign slot_free       = !bus.pipe_we_i || (bus.pipe_waddr_i == ZERO_REG);
    assign empty           = (count == '0);
    assign grant           = slot_free && !empty;
    assign bus.llu_ready_o = (count != CW'(DEPTH));
    // x0 results complete the handshake but are never queued.
    assign push            = bus.llu_valid_i && bus.llu_ready_o && (bus.llu_waddr_i != ZERO_REG);
    assign din             = '{waddr: bus.llu_waddr_i, wdata: bus.llu_wdata_i};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .push      (push),
        .pop       (grant),
        .din       (din),
        .count     (count),
        .head      (head),
        .ent_vld   (ent_vld),
        .ent_waddr (ent_waddr)
    );

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hit = hit | (ent_vld[i] && (ent_waddr[i] == bus.chk_raddr_i));
        end
    end

    assign bus.chk_hit_o = hit && (bus.chk_raddr_i != ZERO_REG);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bus.reg_waddr_o <= ZERO_REG;
            bus.reg_we_o    <= 1'b0;
            bus.reg_wdata_o <= ZERO;
        end else if (!slot_free) begin
            bus.reg_waddr_o <= bus.pipe_waddr_i;
            bus.reg_we_o    <= 1'b1;
            bus.reg_wdata_o <= bus.pipe_wdata_i;
        end else if (grant) begin
            bus.reg_waddr_o <= head.waddr;
            bus.reg_we_o    <= 1'b1;
            bus.reg_wdata_o <= head.wdata;
        end else begin
            bus.reg_we_o    <= 1'b0;
        end
    end

`ifdef WB_ARB_STARVE_EN
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] starve_cnt;
    logic          stall_q;

    // Counter saturates at STARVE_MAX; the request holds until a pop finally happens.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            starve_cnt <= '0;
            stall_q    <= 1'b0;
        end else begin
            if (empty || grant)
                starve_cnt <= '0;
            else if (starve_cnt != SW'(STARVE_MAX))
                starve_cnt <= starve_cnt + SW'(1);

            if (grant)
                stall_q <= 1'b0;
            else if (starve_cnt == SW'(STARVE_MAX))
                stall_q <= 1'b1;
        end
    end

    assign bus.stall_req_o = stall_q;
`else
    assign bus.stall_req_o = 1'b0;
`endif

endmodule
